// File: rtl/cdm_pkg.sv
// ---------------------------------------------------------------------------
// cdm_pkg
// Shared definitions for the layer-memory (CDM) port arbiter:
//   - default address / data / select widths of the CDM port
//   - CSEL encodings of the memory banks behind the port
//   - requester identifiers
//   - sel_legal(): tells whether a select value addresses a real bank
// ---------------------------------------------------------------------------
package cdm_pkg;

    localparam int CDM_AW = 12;  // memory address width
    localparam int CDM_DW = 20;  // memory data width
    localparam int CDM_SW = 3;   // memory select width

    // Bank selects. CSEL_NONE doubles as the idle value of csel.
    localparam logic [CDM_SW-1:0] CSEL_NONE  = 3'd0;
    localparam logic [CDM_SW-1:0] CSEL_L0_K0 = 3'd1;
    localparam logic [CDM_SW-1:0] CSEL_L0_K1 = 3'd2;
    localparam logic [CDM_SW-1:0] CSEL_L1_K0 = 3'd3;
    localparam logic [CDM_SW-1:0] CSEL_L1_K1 = 3'd4;
    localparam logic [CDM_SW-1:0] CSEL_L2    = 3'd5;

    // Requester identifiers: r0 is the layer-0 conv/ReLU engine,
    // r1 the layer-1 max-pool engine.
    typedef enum logic {
        REQ_R0 = 1'b0,
        REQ_R1 = 1'b1
    } req_id_e;

    // Only CSEL_L0_K0..CSEL_L2 map to a bank; everything else is rejected.
    function automatic logic sel_legal(input logic [CDM_SW-1:0] sel);
        return (sel >= CSEL_L0_K0) && (sel <= CSEL_L2);
    endfunction

endpackage : cdm_pkg

// File: rtl/rr_arb2.sv
// ---------------------------------------------------------------------------
// rr_arb2
// Two-way round-robin arbiter with ownership lock and a bounded hold counter.
//
// Ports:
//   clk      in   clock
//   reset    in   asynchronous, active-high reset
//   req_i    in   [1:0] request vector, bit n = requester n
//   lock_i   in   [1:0] lock vector, bit n = requester n wants to keep the port
//   gnt_o    out  [1:0] one-hot (or zero) grant vector, combinational
//   owner_o  out  id of the requester granted this cycle (0 when no grant)
//
// Rules:
//   - a single requester is always granted
//   - on contention the requester not granted last wins, unless the last
//     grantee is locking and has not yet used MAX_HOLD contested grants
//   - the hold counter counts consecutive locked grants to one owner while
//     the other side is waiting; it clears on owner change, lock drop or
//     when the other side goes idle
// ---------------------------------------------------------------------------
module rr_arb2 #(
    parameter int MAX_HOLD = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req_i,
    input  logic [1:0] lock_i,
    output logic [1:0] gnt_o,
    output logic       owner_o
);

    localparam int HW = $clog2(MAX_HOLD + 1);

    // owner_q is the last grantee; owner_vld_q is clear until the first grant
    // after reset, which makes the round-robin pointer favour r0.
    logic          owner_q, owner_d;
    logic          owner_vld_q, owner_vld_d;
    logic [HW-1:0] hold_q, hold_d;

    logic          win;
    logic          hold_ok;

    assign hold_ok = hold_q < HW'(MAX_HOLD);

    // NOTE: every signal assigned in always_comb gets a default first, so no
    // path can leave it unassigned and infer a latch.
    always_comb begin
        win         = 1'b0;
        gnt_o       = 2'b00;
        owner_d     = owner_q;
        owner_vld_d = owner_vld_q;
        hold_d      = '0;

        unique case (req_i)
            2'b01: win = 1'b0;
            2'b10: win = 1'b1;
            2'b11: begin
                if (owner_vld_q && lock_i[owner_q] && hold_ok)
                    win = owner_q;
                else
                    win = owner_vld_q ? ~owner_q : 1'b0;
            end
            default: win = 1'b0;
        endcase

        if (req_i != 2'b00) begin
            gnt_o       = win ? 2'b10 : 2'b01;
            owner_d     = win;
            owner_vld_d = 1'b1;
            // A locked grant while the other side waits counts towards the
            // hold limit; the first such grant of a new owner counts as 1.
            if (lock_i[win] && req_i[~win]) begin
                if (owner_vld_q && (owner_q == win))
                    hold_d = hold_q + HW'(1);
                else
                    hold_d = HW'(1);
            end
        end
    end

    assign owner_o = win;

    // NOTE: sequential state is updated with non-blocking assignments only, so
    // every register samples the values from before the clock edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            owner_q     <= 1'b0;
            owner_vld_q <= 1'b0;
            hold_q      <= '0;
        end else begin
            owner_q     <= owner_d;
            owner_vld_q <= owner_vld_d;
            hold_q      <= hold_d;
        end
    end

endmodule : rr_arb2

// File: rtl/cdm_port_arbiter.sv
// ---------------------------------------------------------------------------
// cdm_port_arbiter
// Shares the single CDM layer-memory port between the layer-0 conv/ReLU
// engine (r0) and the layer-1 max-pool engine (r1). One command per cycle is
// accepted, registered onto the memory pins the following cycle, and read
// data is returned to the issuing requester two cycles after its grant.
//
// Ports:
//   clk, reset                     clock, asynchronous active-high reset
//   rN_req / rN_lock               command valid / keep-ownership request
//   rN_we, rN_sel, rN_addr,        command: 1 = write, bank select, address,
//   rN_wdata                         write data (held stable until rN_gnt)
//   rN_gnt                         command accepted this cycle (combinational)
//   rN_rvalid / rN_rdata           read return strobe / data (data holds)
//   cwr, crd, csel,                registered memory strobes and select
//   caddr_wr, cdata_wr, caddr_rd   registered memory addresses / write data
//   cdata_rd                       memory read data, captured the cycle crd=1
//   sel_err                        sticky: an illegal-sel command was accepted
// ---------------------------------------------------------------------------
module cdm_port_arbiter
    import cdm_pkg::*;
#(
    parameter int AW       = CDM_AW,
    parameter int DW       = CDM_DW,
    parameter int SW       = CDM_SW,
    parameter int MAX_HOLD = 16
) (
    input  logic          clk,
    input  logic          reset,

    input  logic          r0_req,
    input  logic          r0_lock,
    input  logic          r0_we,
    input  logic [SW-1:0] r0_sel,
    input  logic [AW-1:0] r0_addr,
    input  logic [DW-1:0] r0_wdata,
    output logic          r0_gnt,
    output logic          r0_rvalid,
    output logic [DW-1:0] r0_rdata,

    input  logic          r1_req,
    input  logic          r1_lock,
    input  logic          r1_we,
    input  logic [SW-1:0] r1_sel,
    input  logic [AW-1:0] r1_addr,
    input  logic [DW-1:0] r1_wdata,
    output logic          r1_gnt,
    output logic          r1_rvalid,
    output logic [DW-1:0] r1_rdata,

    output logic          cwr,
    output logic          crd,
    output logic [SW-1:0] csel,
    output logic [AW-1:0] caddr_wr,
    output logic [DW-1:0] cdata_wr,
    output logic [AW-1:0] caddr_rd,
    input  logic [DW-1:0] cdata_rd,
    output logic          sel_err
);

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    logic [1:0] arb_gnt;
    logic [1:0] gnt;
    logic       owner;

    rr_arb2 #(
        .MAX_HOLD (MAX_HOLD)
    ) u_arb (
        .clk     (clk),
        .reset   (reset),
        .req_i   ({r1_req, r0_req}),
        .lock_i  ({r1_lock, r0_lock}),
        .gnt_o   (arb_gnt),
        .owner_o (owner)
    );

    // Grants are combinational, so they are masked while reset is held to
    // keep every output at 0 during reset.
    assign gnt    = arb_gnt & {2{~reset}};
    assign r0_gnt = gnt[0];
    assign r1_gnt = gnt[1];

    // ------------------------------------------------------------------
    // Selected command
    // ------------------------------------------------------------------
    logic          cmd_we;
    logic [SW-1:0] cmd_sel;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic          accept;
    logic          legal;
    logic          issue;

    always_comb begin
        cmd_we    = r0_we;
        cmd_sel   = r0_sel;
        cmd_addr  = r0_addr;
        cmd_wdata = r0_wdata;
        if (owner) begin
            cmd_we    = r1_we;
            cmd_sel   = r1_sel;
            cmd_addr  = r1_addr;
            cmd_wdata = r1_wdata;
        end
    end

    assign accept = |gnt;
    assign legal  = sel_legal(cmd_sel);
    // An illegal-sel command is still accepted (the requester must not stall)
    // but it never reaches the memory.
    assign issue  = accept && legal;

    // ------------------------------------------------------------------
    // Memory command register (cycle after grant) and read return stage
    // ------------------------------------------------------------------
    logic          cwr_q, cwr_d;
    logic          crd_q, crd_d;
    logic [SW-1:0] csel_q, csel_d;
    logic [AW-1:0] caddr_wr_q, caddr_wr_d;
    logic [DW-1:0] cdata_wr_q, cdata_wr_d;
    logic [AW-1:0] caddr_rd_q, caddr_rd_d;
    req_id_e       rd_id_q, rd_id_d;
    logic          rv0_q, rv0_d;
    logic          rv1_q, rv1_d;
    logic [DW-1:0] rdata0_q, rdata0_d;
    logic [DW-1:0] rdata1_q, rdata1_d;
    logic          err_q, err_d;

    always_comb begin
        cwr_d      = issue && cmd_we;
        crd_d      = issue && !cmd_we;
        csel_d     = issue ? cmd_sel : SW'(CSEL_NONE);
        caddr_wr_d = (issue && cmd_we)  ? cmd_addr  : '0;
        cdata_wr_d = (issue && cmd_we)  ? cmd_wdata : '0;
        caddr_rd_d = (issue && !cmd_we) ? cmd_addr  : '0;
        rd_id_d    = req_id_e'(owner);
        err_d      = err_q | (accept && !legal);

        // crd_q marks the cycle the memory drives cdata_rd; the data is
        // captured for whoever issued that read and appears one cycle later.
        rv0_d    = crd_q && (rd_id_q == REQ_R0);
        rv1_d    = crd_q && (rd_id_q == REQ_R1);
        rdata0_d = rv0_d ? cdata_rd : rdata0_q;
        rdata1_d = rv1_d ? cdata_rd : rdata1_q;
    end

    // Reset clears the command register and the return stage together, which
    // aborts an in-flight command and any read return still pending.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cwr_q      <= 1'b0;
            crd_q      <= 1'b0;
            csel_q     <= '0;
            caddr_wr_q <= '0;
            cdata_wr_q <= '0;
            caddr_rd_q <= '0;
            rd_id_q    <= REQ_R0;
            rv0_q      <= 1'b0;
            rv1_q      <= 1'b0;
            rdata0_q   <= '0;
            rdata1_q   <= '0;
            err_q      <= 1'b0;
        end else begin
            cwr_q      <= cwr_d;
            crd_q      <= crd_d;
            csel_q     <= csel_d;
            caddr_wr_q <= caddr_wr_d;
            cdata_wr_q <= cdata_wr_d;
            caddr_rd_q <= caddr_rd_d;
            rd_id_q    <= rd_id_d;
            rv0_q      <= rv0_d;
            rv1_q      <= rv1_d;
            rdata0_q   <= rdata0_d;
            rdata1_q   <= rdata1_d;
            err_q      <= err_d;
        end
    end

    assign cwr       = cwr_q;
    assign crd       = crd_q;
    assign csel      = csel_q;
    assign caddr_wr  = caddr_wr_q;
    assign cdata_wr  = cdata_wr_q;
    assign caddr_rd  = caddr_rd_q;
    assign r0_rvalid = rv0_q;
    assign r1_rvalid = rv1_q;
    assign r0_rdata  = rdata0_q;
    assign r1_rdata  = rdata1_q;
    assign sel_err   = err_q;

endmodule : cdm_port_arbiter

// File: tb/tb_cdm_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_cdm_port_arbiter
// Directed bench for the CDM port arbiter. Each requester is fed from a
// command queue; a transaction-level model of the arbitration rules and of
// the memory decides which command must be granted every cycle, what must
// appear on the memory pins and what must come back to each requester.
// A bench-side memory answers the DUT's read strobes.
// ---------------------------------------------------------------------------
module tb_cdm_port_arbiter;
    import cdm_pkg::*;

    localparam int AW       = 12;
    localparam int DW       = 20;
    localparam int SW       = 3;
    localparam int MAX_HOLD = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          r0_req, r0_lock, r0_we, r0_gnt, r0_rvalid;
    logic [SW-1:0] r0_sel;
    logic [AW-1:0] r0_addr;
    logic [DW-1:0] r0_wdata, r0_rdata;
    logic          r1_req, r1_lock, r1_we, r1_gnt, r1_rvalid;
    logic [SW-1:0] r1_sel;
    logic [AW-1:0] r1_addr;
    logic [DW-1:0] r1_wdata, r1_rdata;
    logic          cwr, crd, sel_err;
    logic [SW-1:0] csel;
    logic [AW-1:0] caddr_wr, caddr_rd;
    logic [DW-1:0] cdata_wr, cdata_rd;

    always #5 clk = ~clk;

    cdm_port_arbiter #(
        .AW (AW), .DW (DW), .SW (SW), .MAX_HOLD (MAX_HOLD)
    ) dut (
        .clk       (clk),       .reset     (reset),
        .r0_req    (r0_req),    .r0_lock   (r0_lock),   .r0_we     (r0_we),
        .r0_sel    (r0_sel),    .r0_addr   (r0_addr),   .r0_wdata  (r0_wdata),
        .r0_gnt    (r0_gnt),    .r0_rvalid (r0_rvalid), .r0_rdata  (r0_rdata),
        .r1_req    (r1_req),    .r1_lock   (r1_lock),   .r1_we     (r1_we),
        .r1_sel    (r1_sel),    .r1_addr   (r1_addr),   .r1_wdata  (r1_wdata),
        .r1_gnt    (r1_gnt),    .r1_rvalid (r1_rvalid), .r1_rdata  (r1_rdata),
        .cwr       (cwr),       .crd       (crd),       .csel      (csel),
        .caddr_wr  (caddr_wr),  .cdata_wr  (cdata_wr),  .caddr_rd  (caddr_rd),
        .cdata_rd  (cdata_rd),  .sel_err   (sel_err)
    );

    typedef struct {
        bit            lock;
        bit            we;
        logic [SW-1:0] sel;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } cmd_t;

    cmd_t q0[$];
    cmd_t q1[$];

    int n_cmp = 0;
    int n_bad = 0;

    // DUT grants in order (0 = r0, 1 = r1), for the literal pattern checks.
    int gtrace[$];

    // Bench-side memory (driven by DUT pins) and model memory.
    logic [DW-1:0] dmem[int];
    logic [DW-1:0] mmem[int];

    // Model state.
    int            m_last;
    bit            m_vld;
    int            m_hold;
    bit            e_cwr, e_crd, e_err;
    logic [SW-1:0] e_csel;
    logic [AW-1:0] e_aw, e_ar;
    logic [DW-1:0] e_dw;
    int            e_rid;
    bit            e_rv[2];
    logic [DW-1:0] e_rd[2];

    function automatic logic [DW-1:0] init_val(input int a);
        return 20'h50000 + DW'(a);
    endfunction

    function automatic logic [DW-1:0] dmem_rd(input int a);
        return dmem.exists(a) ? dmem[a] : init_val(a);
    endfunction

    function automatic logic [DW-1:0] mmem_rd(input int a);
        return mmem.exists(a) ? mmem[a] : init_val(a);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_last = 0; m_vld = 1'b0; m_hold = 0;
        e_cwr = 1'b0; e_crd = 1'b0; e_err = 1'b0;
        e_csel = '0; e_aw = '0; e_ar = '0; e_dw = '0; e_rid = 0;
        e_rv[0] = 1'b0; e_rv[1] = 1'b0;
        e_rd[0] = '0;   e_rd[1] = '0;
    endtask

    function automatic cmd_t idle_cmd();
        cmd_t c;
        c.lock = 1'b0; c.we = 1'b0; c.sel = '0; c.addr = '0; c.wdata = '0;
        return c;
    endfunction

    task automatic push(input int who, input bit lock, input bit we, input int sel,
                        input int addr, input int wdata);
        cmd_t c;
        c.lock = lock; c.we = we; c.sel = SW'(sel); c.addr = AW'(addr); c.wdata = DW'(wdata);
        if (who == 0) q0.push_back(c); else q1.push_back(c);
    endtask

    // One clock cycle: serve memory, drive queue heads, compare against the
    // model, then advance the model by one clock.
    task automatic step();
        cmd_t c0, c1, c;
        int   g;
        bit   nrv[2];
        @(negedge clk);
        if (cwr) dmem[int'(caddr_wr)] = cdata_wr;
        cdata_rd = crd ? dmem_rd(int'(caddr_rd)) : '0;

        c0 = (q0.size() > 0) ? q0[0] : idle_cmd();
        c1 = (q1.size() > 0) ? q1[0] : idle_cmd();
        r0_req = (q0.size() > 0); r0_lock = c0.lock; r0_we = c0.we;
        r0_sel = c0.sel; r0_addr = c0.addr; r0_wdata = c0.wdata;
        r1_req = (q1.size() > 0); r1_lock = c1.lock; r1_we = c1.we;
        r1_sel = c1.sel; r1_addr = c1.addr; r1_wdata = c1.wdata;
        #1;

        // Who must be granted.
        if (reset || (!r0_req && !r1_req)) g = -1;
        else if (r0_req && !r1_req) g = 0;
        else if (!r0_req && r1_req) g = 1;
        else if (m_vld && ((m_last == 0) ? c0.lock : c1.lock) && m_hold < MAX_HOLD) g = m_last;
        else g = m_vld ? 1 - m_last : 0;

        check("r0_gnt",    32'(r0_gnt),    32'(g == 0));
        check("r1_gnt",    32'(r1_gnt),    32'(g == 1));
        check("cwr",       32'(cwr),       32'(e_cwr));
        check("crd",       32'(crd),       32'(e_crd));
        check("csel",      32'(csel),      32'(e_csel));
        check("caddr_wr",  32'(caddr_wr),  32'(e_aw));
        check("cdata_wr",  32'(cdata_wr),  32'(e_dw));
        check("caddr_rd",  32'(caddr_rd),  32'(e_ar));
        check("r0_rvalid", 32'(r0_rvalid), 32'(e_rv[0]));
        check("r1_rvalid", 32'(r1_rvalid), 32'(e_rv[1]));
        check("r0_rdata",  32'(r0_rdata),  32'(e_rd[0]));
        check("r1_rdata",  32'(r1_rdata),  32'(e_rd[1]));
        check("sel_err",   32'(sel_err),   32'(e_err));

        if (r0_gnt || r1_gnt) gtrace.push_back(r1_gnt ? 1 : 0);
        if (reset) return;

        // Read return: a read on the pins this cycle is delivered next cycle.
        nrv[0] = 1'b0; nrv[1] = 1'b0;
        if (e_crd) begin
            nrv[e_rid]  = 1'b1;
            e_rd[e_rid] = mmem_rd(int'(e_ar));
        end
        e_rv[0] = nrv[0]; e_rv[1] = nrv[1];
        if (e_cwr) mmem[int'(e_aw)] = e_dw;

        // Pins next cycle.
        e_cwr = 1'b0; e_crd = 1'b0; e_csel = '0; e_aw = '0; e_ar = '0; e_dw = '0;
        if (g >= 0) begin
            c = (g == 0) ? c0 : c1;
            if (c.sel < 1 || c.sel > 5) e_err = 1'b1;
            else if (c.we) begin
                e_cwr = 1'b1; e_csel = c.sel; e_aw = c.addr; e_dw = c.wdata;
            end else begin
                e_crd = 1'b1; e_csel = c.sel; e_ar = c.addr; e_rid = g;
            end
            // Run length of locked grants to one owner while the other waits.
            if (c.lock && ((g == 0) ? r1_req : r0_req))
                m_hold = (m_vld && m_last == g) ? m_hold + 1 : 1;
            else
                m_hold = 0;
            m_last = g;
            m_vld  = 1'b1;
            if (g == 0) void'(q0.pop_front()); else void'(q1.pop_front());
        end else begin
            m_hold = 0;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        q0.delete(); q1.delete();
        model_reset();
        step();
        step();
        reset = 1'b0;
        gtrace.delete();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    int lead0;
    int ones;

    initial begin
        reset = 1'b1;
        cdata_rd = '0;
        r0_req = 0; r0_lock = 0; r0_we = 0; r0_sel = '0; r0_addr = '0; r0_wdata = '0;
        r1_req = 0; r1_lock = 0; r1_we = 0; r1_sel = '0; r1_addr = '0; r1_wdata = '0;

        // 1: single write from r0.
        do_reset();
        push(0, 0, 1, 1, 'h005, 'h01310);
        step();
        check("t1 r0_gnt", 32'(r0_gnt), 32'd1);
        step();
        check("t1 cwr",      32'(cwr),      32'd1);
        check("t1 caddr_wr", 32'(caddr_wr), 32'h005);
        check("t1 cdata_wr", 32'(cdata_wr), 32'h01310);
        check("t1 csel",     32'(csel),     32'd1);
        step();
        check("t1 cwr idle", 32'(cwr), 32'd0);

        // 2: both requesters streaming reads, no lock.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            push(0, 0, 0, 3, 'h010 + i, 0);
            push(1, 0, 0, 4, 'h210 + i, 0);
        end
        step(); step(); step();
        check("t2 r0_rvalid", 32'(r0_rvalid), 32'd1);
        check("t2 r0_rdata",  32'(r0_rdata),  32'h50010);
        check("t2 r1_rvalid", 32'(r1_rvalid), 32'd0);
        idle(5);
        check("t2 n grants", 32'(gtrace.size()), 32'd6);
        for (int i = 0; i < 6 && i < gtrace.size(); i++)
            check("t2 rr order", 32'(gtrace[i]), 32'(i % 2));

        // 3: r0 locks with 20 writes while r1 waits with one read.
        do_reset();
        for (int i = 0; i < 20; i++) push(0, 1, 1, 2, 'h100 + i, 'h30000 + i);
        push(1, 0, 0, 4, 'h300, 0);
        idle(24);
        lead0 = 0;
        while (lead0 < gtrace.size() && gtrace[lead0] == 0) lead0++;
        ones = 0;
        foreach (gtrace[i]) ones += gtrace[i];
        check("t3 n grants", 32'(gtrace.size()), 32'd21);
        check("t3 held",     32'(lead0),         32'd16);
        check("t3 r1 once",  32'(ones),          32'd1);

        // 4: write then read back the same address.
        do_reset();
        push(0, 0, 1, 1, 'h040, 'h0ABCD);
        push(0, 0, 0, 1, 'h040, 0);
        step(); step();
        check("t4 cwr",      32'(cwr),      32'd1);
        check("t4 caddr_wr", 32'(caddr_wr), 32'h040);
        step();
        check("t4 crd",      32'(crd),      32'd1);
        check("t4 caddr_rd", 32'(caddr_rd), 32'h040);
        step();
        check("t4 r0_rvalid", 32'(r0_rvalid), 32'd1);
        check("t4 r0_rdata",  32'(r0_rdata),  32'h0ABCD);
        idle(2);

        // 5: illegal selects are granted but never reach memory.
        do_reset();
        push(1, 0, 0, 0, 'h077, 0);
        step();
        check("t5 r1_gnt", 32'(r1_gnt), 32'd1);
        step();
        check("t5 crd",     32'(crd),     32'd0);
        check("t5 cwr",     32'(cwr),     32'd0);
        check("t5 sel_err", 32'(sel_err), 32'd1);
        step();
        check("t5 r1_rvalid", 32'(r1_rvalid), 32'd0);
        push(0, 0, 1, 6, 'h078, 'h11111);
        push(1, 0, 1, 5, 'h079, 'h22222);
        idle(4);
        check("t5 sel_err sticky", 32'(sel_err), 32'd1);

        // 6: reset in the cycle after a read grant.
        do_reset();
        push(0, 0, 0, 1, 'h020, 0);
        step();
        @(posedge clk);
        #1;
        reset = 1'b1;
        q0.delete(); q1.delete();
        model_reset();
        #1;
        check("t6 crd aborted", 32'(crd), 32'd0);
        step();
        step();
        reset = 1'b0;
        idle(2);
        gtrace.delete();
        push(0, 0, 0, 2, 'h021, 0);
        push(1, 0, 0, 3, 'h022, 0);
        step();
        check("t6 ptr r0", 32'(r0_gnt), 32'd1);
        idle(4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_cdm_port_arbiter
